// File: rtl/three_a_minus_two_b_seq.sv
// three_a_minus_two_b_seq
//   Multi-cycle sequencer computing 3A - 2B through one shared external
//   adder-subtractor. The state machine steps 2A, 3A, 2B, then 3A - 2B.
//   Each step's adder output and flags are registered on the edge that
//   leaves the state. A valid/ready handshake is used on both sides.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   in_valid/in_ready           input handshake for a_in, b_in, signed_mode
//   add_a/add_b/add_sub/
//   add_signed                  drive to the adder (add_sub = 1 subtracts)
//   add_result/add_carry/
//   add_overflow/add_borrow     adder outputs, sampled each compute step
//   out_valid/out_ready         output handshake
//   result                      3A - 2B modulo 2^WIDTH
//   overflow                    sticky signed overflow over all steps
//   carry                       sticky carry from the three add steps
//   borrow                      borrow from the final subtract
//
// Optional feature (macro SEQ_SKIP_ZERO_B_EN)
//   When defined, a zero B skips the 2B and subtract steps. The result is
//   then 3A with borrow = 0, after a latency of 2 cycles instead of 4.

module three_a_minus_two_b_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    output logic             add_signed,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_carry,
    input  logic             add_overflow,
    input  logic             add_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             borrow
);

    typedef enum logic [2:0] {
        StIdle,
        StTwoA,
        StThreeA,
        StTwoB,
        StSub,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, two_a_q, three_a_q, two_b_q, result_q;
    logic             s_q, overflow_q, carry_q, borrow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and adder drive; operands come only from registers.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_sub    = 1'b0;
        add_signed = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StTwoA;
            end
            StTwoA: begin
                add_a      = a_q;
                add_b      = a_q;
                add_signed = s_q;
                state_d    = StThreeA;
            end
            StThreeA: begin
                add_a      = two_a_q;
                add_b      = a_q;
                add_signed = s_q;
`ifdef SEQ_SKIP_ZERO_B_EN
                state_d    = (b_q == '0) ? StDone : StTwoB;
`else
                state_d    = StTwoB;
`endif
            end
            StTwoB: begin
                add_a      = b_q;
                add_b      = b_q;
                add_signed = s_q;
                state_d    = StSub;
            end
            StSub: begin
                add_a      = three_a_q;
                add_b      = two_b_q;
                add_sub    = 1'b1;
                add_signed = s_q;
                state_d    = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath capture. The handshake only occurs in StIdle, so it never
    // collides with a compute-step capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= 1'b0;
            two_a_q    <= '0;
            three_a_q  <= '0;
            two_b_q    <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                a_q        <= a_in;
                b_q        <= b_in;
                s_q        <= signed_mode;
                overflow_q <= 1'b0;
                carry_q    <= 1'b0;
                borrow_q   <= 1'b0;
            end
            case (state_q)
                StTwoA: begin
                    two_a_q    <= add_result;
                    carry_q    <= carry_q | add_carry;
                    overflow_q <= overflow_q | (add_overflow & s_q);
                end
                StThreeA: begin
                    three_a_q  <= add_result;
                    carry_q    <= carry_q | add_carry;
                    overflow_q <= overflow_q | (add_overflow & s_q);
`ifdef SEQ_SKIP_ZERO_B_EN
                    // Borrow was already cleared at the handshake.
                    if (b_q == '0) result_q <= add_result;
`endif
                end
                StTwoB: begin
                    two_b_q    <= add_result;
                    carry_q    <= carry_q | add_carry;
                    overflow_q <= overflow_q | (add_overflow & s_q);
                end
                StSub: begin
                    // The carry of the subtract step is deliberately not merged.
                    result_q   <= add_result;
                    borrow_q   <= add_borrow;
                    overflow_q <= overflow_q | (add_overflow & s_q);
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;

endmodule

// File: tb/tb_three_a_minus_two_b_seq.sv
module tb_three_a_minus_two_b_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        signed_mode;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic        add_signed;
    logic [15:0] add_result;
    logic        add_carry;
    logic        add_overflow;
    logic        add_borrow;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        carry;
    logic        borrow;

    int checks   = 0;
    int failures = 0;

    three_a_minus_two_b_seq #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .signed_mode  (signed_mode),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sub      (add_sub),
        .add_signed   (add_signed),
        .add_result   (add_result),
        .add_carry    (add_carry),
        .add_overflow (add_overflow),
        .add_borrow   (add_borrow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .overflow     (overflow),
        .carry        (carry),
        .borrow       (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder-subtractor. Subtract carry is the inverted borrow,
    // so a sequencer that wrongly merges it would show up in the carry flag.
    logic [16:0] wide;
    always_comb begin
        wide = '0;
        if (add_sub) wide = {1'b0, add_a} - {1'b0, add_b};
        else         wide = {1'b0, add_a} + {1'b0, add_b};
        add_result = wide[15:0];
        add_carry  = add_sub ? ~wide[16] : wide[16];
        add_borrow = add_sub ? wide[16] : 1'b0;
        if (add_sub)
            add_overflow = add_signed && (add_a[15] != add_b[15])
                           && (wide[15] != add_a[15]);
        else
            add_overflow = add_signed && (add_a[15] == add_b[15])
                           && (wide[15] != add_a[15]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake at the next edge; returns just after it.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        a_in        = a;
        b_in        = b;
        signed_mode = s;
        step();
        in_valid    = 1'b0;
        a_in        = 16'hdead;
        b_in        = 16'hbeef;
        signed_mode = 1'b0;
    endtask

    // Counts edges since the handshake until out_valid, bounded.
    task automatic wait_out(input int exp_lat, input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    task automatic consume(input logic [15:0] exp_result, input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_high"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_result_kept"}, {16'd0, result}, {16'd0, exp_result});
    endtask

    initial begin
        int lat4;
        reset       = 1'b1;
        in_valid    = 1'b0;
        a_in        = '0;
        b_in        = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, overflow, carry, borrow}, 32'd0);
        chk("rst_add_a", {16'd0, add_a}, 32'd0);
        step();
        reset = 1'b0;

        // T1: unsigned 5, 3 -> 9, stepped state by state; busy input ignored
        send(16'h0005, 16'h0003, 1'b0);
        in_valid = 1'b1;
        a_in     = 16'h7777;
        b_in     = 16'h1111;
        chk("t1_two_a_add_a", {16'd0, add_a}, 32'h5);
        chk("t1_two_a_add_b", {16'd0, add_b}, 32'h5);
        chk("t1_two_a_ctl", {30'd0, add_sub, add_signed}, 32'd0);
        chk("t1_busy_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("t1_three_a_add_a", {16'd0, add_a}, 32'hA);
        chk("t1_three_a_add_b", {16'd0, add_b}, 32'h5);
        step();
        chk("t1_two_b_add_a", {16'd0, add_a}, 32'h3);
        chk("t1_two_b_add_b", {16'd0, add_b}, 32'h3);
        step();
        chk("t1_sub_add_a", {16'd0, add_a}, 32'hF);
        chk("t1_sub_add_b", {16'd0, add_b}, 32'h6);
        chk("t1_sub_add_sub", {31'd0, add_sub}, 32'd1);
        chk("t1_sub_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        step();
        chk("t1_done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", {16'd0, result}, 32'h9);
        chk("t1_flags", {29'd0, overflow, carry, borrow}, 32'd0);
        chk("t1_done_add_a", {16'd0, add_a}, 32'd0);
        consume(16'h0009, "t1");

        // T2: unsigned 2, 5 -> 0xFFFC with borrow; backpressure, queued input
        send(16'h0002, 16'h0005, 1'b0);
        wait_out(4, "t2_latency");
        in_valid = 1'b1;
        a_in     = 16'h0001;
        b_in     = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_result", {16'd0, result}, 32'hFFFC);
            chk("t2_hold_flags", {29'd0, overflow, carry, borrow}, 32'd1);
            chk("t2_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_out_valid_low", {31'd0, out_valid}, 32'd0);
        chk("t2_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("t2_result_kept", {16'd0, result}, 32'hFFFC);
        chk("t2_borrow_kept", {31'd0, borrow}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t2_second_taken", {31'd0, in_ready}, 32'd0);
        wait_out(4, "t2b_latency");
        chk("t2b_result", {16'd0, result}, 32'h1);
        chk("t2b_flags", {29'd0, overflow, carry, borrow}, 32'd0);
        consume(16'h0001, "t2b");

        // T3: unsigned 0x9000, 1 -> carry from 2A
        send(16'h9000, 16'h0001, 1'b0);
        wait_out(4, "t3_latency");
        chk("t3_result", {16'd0, result}, 32'hAFFE);
        chk("t3_flags", {29'd0, overflow, carry, borrow}, 32'b010);
        consume(16'hAFFE, "t3");

        // T4: signed 0x3000, 0 -> overflow in 3A
`ifdef SEQ_SKIP_ZERO_B_EN
        lat4 = 2;
`else
        lat4 = 4;
`endif
        send(16'h3000, 16'h0000, 1'b1);
        wait_out(lat4, "t4_latency");
        chk("t4_result", {16'd0, result}, 32'h9000);
        chk("t4_flags", {29'd0, overflow, carry, borrow}, 32'b100);
        consume(16'h9000, "t4");

        // Reset during THREE_A aborts and clears everything at once
        send(16'h9000, 16'h0001, 1'b0);
        step();
        chk("rst_pre_carry", {31'd0, carry}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_result", {16'd0, result}, 32'd0);
        chk("rst_mid_flags", {29'd0, overflow, carry, borrow}, 32'd0);
        chk("rst_mid_add", {14'd0, add_a, add_sub, add_signed}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rst_post_out_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0001, 16'h0001, 1'b0);
        wait_out(4, "t5_latency");
        chk("t5_result", {16'd0, result}, 32'h1);
        chk("t5_flags", {29'd0, overflow, carry, borrow}, 32'd0);
        consume(16'h0001, "t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/three_a_minus_two_b_seq.md
Name: three_a_minus_two_b_seq

Overview:
- Multi-cycle sequencer that computes 3A - 2B over a single shared 16-bit adder-subtractor stage.
- Sits directly upstream of that stage: drives its operand and control inputs, registers its Output and flags each step, and returns one result per transaction.
- Valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 16, datapath width. It must match the adder-subtractor width; only 16 is supported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a_in, b_in and signed_mode are valid
- in_ready  output  1  block can accept a new transaction
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- signed_mode  input  1  1 = two's-complement (drives adder s=1); 0 = unsigned
- add_a  output  WIDTH  adder operand A
- add_b  output  WIDTH  adder operand B
- add_sub  output  1  adder add/subtract select (1 = subtract)
- add_signed  output  1  adder signed select
- add_result  input  WIDTH  adder Output
- add_carry  input  1  adder Carry
- add_overflow  input  1  adder Overflow
- add_borrow  input  1  adder Borrow
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  3A - 2B, modulo 2^WIDTH
- overflow  output  1  sticky signed overflow
- carry  output  1  sticky unsigned carry from the add steps
- borrow  output  1  unsigned borrow from the final subtract

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Reset clears: state = IDLE, in_ready = 1, out_valid = 0, result = 0, overflow = carry = borrow = 0, all internal registers = 0.
- Reset mid-transaction aborts the operation; no partial result is ever presented.
- State machine:
  - IDLE -> TWO_A -> THREE_A -> TWO_B -> SUB -> DONE -> IDLE.
  - in_ready = 1 only in IDLE.
  - The handshake (in_valid & in_ready) at edge N latches a_in, b_in and signed_mode into A_r, B_r and S_r, and moves to TWO_A.
- Adder drive per state (combinational from registers; add_signed = S_r in every non-IDLE state):
  - TWO_A: add_a = A_r, add_b = A_r, add_sub = 0; capture 2A.
  - THREE_A: add_a = 2A, add_b = A_r, add_sub = 0; capture 3A.
  - TWO_B: add_a = B_r, add_b = B_r, add_sub = 0; capture 2B.
  - SUB: add_a = 3A, add_b = 2B, add_sub = 1; capture result and borrow.
  - IDLE / DONE: add_a = add_b = 0, add_sub = 0, add_signed = 0.
- Each state lasts exactly one cycle; the capture happens on the edge that leaves the state.
- Latency: out_valid rises at edge N+4, i.e. 4 cycles after the input handshake.
- Flags:
  - overflow = OR of add_overflow sampled in all four compute steps. It can only be set when S_r = 1.
  - carry = OR of add_carry sampled in TWO_A, THREE_A and TWO_B only. The SUB-step carry is ignored.
  - borrow = add_borrow sampled in SUB.
  - All flags clear on each new input handshake.
- Output side:
  - DONE holds out_valid = 1; result and flags are stable while out_ready = 0.
  - out_valid & out_ready -> IDLE with out_valid = 0. result and flags keep their values until the next handshake.
- Boundary conditions:
  - in_valid while busy is ignored (in_ready = 0); operands are not re-sampled.
  - in_valid together with out_ready in DONE: the result is consumed, and the new input is taken on the following cycle in IDLE.
  - Wrap-around: all intermediates are truncated to WIDTH bits; no saturation.

Optional Feature:
- Macro: SEQ_SKIP_ZERO_B_EN.
- Defined: if B_r == 0 at the exit of THREE_A, the block skips TWO_B and SUB and goes directly to DONE with result = 3A and borrow = 0. Latency is then 2 cycles; overflow and carry cover TWO_A and THREE_A only.
- Undefined: the fixed 4-step sequence always runs.

Test Plan:
- Unsigned, a_in=0x0005, b_in=0x0003 -> out_valid 4 cycles after the handshake; result=0x0009, overflow=0, carry=0, borrow=0.
- Unsigned, a_in=0x0002, b_in=0x0005 -> result=0xFFFC, borrow=1, carry=0.
- Unsigned, a_in=0x9000, b_in=0x0001 -> 2A step carries out; carry=1, result=0xAFFE, borrow=0.
- Signed, a_in=0x3000, b_in=0x0000 -> THREE_A step overflows; overflow=1, result=0x9000.
  - With SEQ_SKIP_ZERO_B_EN: out_valid 2 cycles after the handshake with the same values.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0; a second in_valid is not accepted until the cycle after the out handshake.
- Assert reset during THREE_A -> out_valid=0, in_ready=1 and all outputs 0 immediately. The next transaction a_in=0x0001, b_in=0x0001 yields result=0x0001.
